// File: rtl/bus_read_responder.sv
// Responder side of the internal bus read handshake: turns each accepted request into one
// non-pipelined 80386-style T1/T2 read cycle and returns the sampled word (or an error on timeout).
module bus_read_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        bus_read_vaild,
   output logic        bus_read_ready,
   input  logic [31:0] bus_read_address,
   output logic [31:0] bus_read_data,
   input  logic        bus_read_code,
   output logic        bus_read_error,
   output logic        busy,
   output logic        ADS_n,
   output logic [29:0] A,
   output logic [3:0]  BE_n,
   output logic        W_R_n,
   output logic        D_C_n,
   output logic        M_IO_n,
   input  logic [31:0] D,
   input  logic        READY_n
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T1,
      ST_T2,
      ST_RESPOND,
      ST_RELEASE
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       accept;
   logic       complete;
   logic       expire;

   // Fetches are always word aligned, so the byte-offset bits carry no information.
   logic       unused_addr_bits;
   assign unused_addr_bits = ^bus_read_address[1:0];

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      complete  = 1'b0;
      expire    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus_read_vaild) begin
               accept    = 1'b1;
               state_nxt = ST_T1;
            end
         end
         ST_T1: state_nxt = ST_T2;
         ST_T2: begin
            // READY_n takes priority over the watchdog on the final wait cycle.
            if (!READY_n) begin
               complete  = 1'b1;
               state_nxt = ST_RESPOND;
            end else if (wait_cnt == WAIT_LAST) begin
               expire    = 1'b1;
               state_nxt = ST_RESPOND;
            end
         end
         ST_RESPOND: state_nxt = ST_RELEASE;
         ST_RELEASE: begin
            // Wait for the initiator to drop its request so a stale valid is never re-accepted.
            if (!bus_read_vaild) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         A              <= '0;
         D_C_n          <= 1'b1;
         wait_cnt       <= '0;
         bus_read_data  <= '0;
         bus_read_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            A     <= bus_read_address[31:2];
            D_C_n <= ~bus_read_code;
         end
         if (state == ST_T1) begin
            wait_cnt <= '0;
         end else if ((state == ST_T2) && !complete && !expire) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (complete) begin
            bus_read_data  <= D;
            bus_read_error <= 1'b0;
         end else if (expire) begin
            bus_read_data  <= 32'hFFFF_FFFF;
            bus_read_error <= 1'b1;
         end
      end
   end

   assign ADS_n          = (state != ST_T1);
   assign BE_n           = ((state == ST_T1) || (state == ST_T2)) ? 4'h0 : 4'hF;
   assign bus_read_ready = (state == ST_RESPOND);
   assign busy           = (state != ST_IDLE);
   assign W_R_n          = 1'b0;
   assign M_IO_n         = 1'b1;

endmodule

// File: tb/tb_bus_read_responder.sv
// Directed bench for bus_read_responder with a short watchdog (TIMEOUT_CYCLES = 4).
module tb_bus_read_responder;

   logic        clock;
   logic        reset_n;
   logic        bus_read_vaild;
   logic        bus_read_ready;
   logic [31:0] bus_read_address;
   logic [31:0] bus_read_data;
   logic        bus_read_code;
   logic        bus_read_error;
   logic        busy;
   logic        ADS_n;
   logic [29:0] A;
   logic [3:0]  BE_n;
   logic        W_R_n;
   logic        D_C_n;
   logic        M_IO_n;
   logic [31:0] D;
   logic        READY_n;

   int n_cmp  = 0;
   int n_fail = 0;

   // Per-read observations filled in by do_read
   int          r_lat;
   int          r_ads;
   int          r_extra;
   int          r_rel;
   bit          r_stable;
   logic [31:0] r_data;
   logic [31:0] r_data2;
   logic        r_err;
   logic        r_after;
   logic [3:0]  r_be_resp;

   bus_read_responder #(.TIMEOUT_CYCLES(4)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .bus_read_vaild   (bus_read_vaild),
      .bus_read_ready   (bus_read_ready),
      .bus_read_address (bus_read_address),
      .bus_read_data    (bus_read_data),
      .bus_read_code    (bus_read_code),
      .bus_read_error   (bus_read_error),
      .busy             (busy),
      .ADS_n            (ADS_n),
      .A                (A),
      .BE_n             (BE_n),
      .W_R_n            (W_R_n),
      .D_C_n            (D_C_n),
      .M_IO_n           (M_IO_n),
      .D                (D),
      .READY_n          (READY_n)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "global timeout");
   end

   // Issues one request and plays the memory side: READY_n goes low on T2 number `waits`
   // (0-based). After acceptance the request attributes are scrambled on purpose.
   task automatic do_read(input logic [31:0] addr, input logic code, input int waits,
                          input logic [31:0] word, input bit stray, input int hold);
      int t2;
      t2 = 0;
      r_lat = -1; r_ads = 0; r_extra = 0; r_rel = -1; r_stable = 1'b1;
      r_data = 'x; r_data2 = 'x; r_err = 1'bx; r_after = 1'bx; r_be_resp = 'x;
      bus_read_address = addr;
      bus_read_code    = code;
      bus_read_vaild   = 1'b1;
      READY_n          = !stray;
      D                = ~word;
      for (int c = 1; c <= 40 && r_lat < 0; c++) begin
         @(negedge clock);
         if (bus_read_ready) begin
            r_lat     = c;
            r_data    = bus_read_data;
            r_err     = bus_read_error;
            r_be_resp = BE_n;
         end else if (!ADS_n) begin
            r_ads++;
            if (A !== addr[31:2] || D_C_n !== ~code || BE_n !== 4'h0) r_stable = 1'b0;
            bus_read_address = ~addr;
            bus_read_code    = ~code;
            READY_n          = !stray;
         end else if (busy && BE_n == 4'h0) begin
            if (A !== addr[31:2] || D_C_n !== ~code) r_stable = 1'b0;
            READY_n = (t2 == waits) ? 1'b0 : 1'b1;
            D       = (t2 == waits) ? word : (word ^ 32'h0F0F_0F0F) + 32'(t2);
            t2++;
         end
      end
      READY_n = 1'b1;
      D       = 32'h0;
      if (hold == 0) bus_read_vaild = 1'b0;
      for (int k = 1; k <= hold + 5; k++) begin
         @(negedge clock);
         if (k == 1) begin
            r_after = bus_read_ready;
            r_data2 = bus_read_data;
         end
         if (!ADS_n || bus_read_ready) r_extra++;
         if (k > hold && !busy) begin
            r_rel = k - hold;
            break;
         end
         if (k == hold) bus_read_vaild = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; bus_read_vaild = 1'b0; bus_read_address = 32'h0;
      bus_read_code = 1'b0; D = 32'h0; READY_n = 1'b1;
      @(negedge clock);
      n_cmp++; if (ADS_n !== 1'b1) begin n_fail++; $display("FAIL rst_ads: got %b want 1", ADS_n); end
      n_cmp++; if (BE_n !== 4'hF) begin n_fail++; $display("FAIL rst_be: got %h want F", BE_n); end
      n_cmp++; if (A !== 30'h0) begin n_fail++; $display("FAIL rst_a: got %h want 0", A); end
      n_cmp++; if (D_C_n !== 1'b1) begin n_fail++; $display("FAIL rst_dc: got %b want 1", D_C_n); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (bus_read_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus_read_ready); end
      n_cmp++; if (bus_read_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus_read_data); end
      n_cmp++; if (bus_read_error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus_read_error); end
      n_cmp++; if (W_R_n !== 1'b0) begin n_fail++; $display("FAIL w_r_n: got %b want 0", W_R_n); end
      n_cmp++; if (M_IO_n !== 1'b1) begin n_fail++; $display("FAIL m_io_n: got %b want 1", M_IO_n); end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_zero_wait();
      do_read(32'h0000_1003, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 0);
      n_cmp++; if (r_lat !== 3) begin n_fail++; $display("FAIL zw_latency: got %0d want 3", r_lat); end
      n_cmp++; if (r_ads !== 1) begin n_fail++; $display("FAIL zw_ads_cycles: got %0d want 1", r_ads); end
      n_cmp++; if (r_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zw_data: got %h want deadbeef", r_data); end
      n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL zw_err: got %b want 0", r_err); end
      n_cmp++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL zw_addr_stable: got %b want 1", r_stable); end
      n_cmp++; if (A !== 30'h0000_0400) begin n_fail++; $display("FAIL zw_a: got %h want 0000400", A); end
      n_cmp++; if (D_C_n !== 1'b0) begin n_fail++; $display("FAIL zw_dc: got %b want 0", D_C_n); end
      n_cmp++; if (r_be_resp !== 4'hF) begin n_fail++; $display("FAIL zw_be_respond: got %h want F", r_be_resp); end
      n_cmp++; if (r_after !== 1'b0) begin n_fail++; $display("FAIL zw_ready_pulse_width: got %b want 0", r_after); end
      n_cmp++; if (r_data2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zw_data_hold: got %h want deadbeef", r_data2); end
      n_cmp++; if (r_rel !== 2) begin n_fail++; $display("FAIL zw_release: got %0d want 2", r_rel); end
   endtask

   // Three waits with TIMEOUT_CYCLES = 4 also lands READY_n on the watchdog's last edge.
   task automatic test_wait_states();
      do_read(32'h0000_2000, 1'b0, 3, 32'h1234_5678, 1'b0, 0);
      n_cmp++; if (r_lat !== 6) begin n_fail++; $display("FAIL ws_latency: got %0d want 6", r_lat); end
      n_cmp++; if (r_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ws_data: got %h want 12345678", r_data); end
      n_cmp++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL ws_err_ready_wins: got %b want 0", r_err); end
      n_cmp++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL ws_addr_stable: got %b want 1", r_stable); end
      n_cmp++; if (D_C_n !== 1'b1) begin n_fail++; $display("FAIL ws_dc: got %b want 1", D_C_n); end
   endtask

   task automatic test_held_valid();
      do_read(32'h0000_0040, 1'b1, 1, 32'hA5A5_0001, 1'b0, 5);
      n_cmp++; if (r_lat !== 4) begin n_fail++; $display("FAIL hv_latency: got %0d want 4", r_lat); end
      n_cmp++; if (r_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL hv_data: got %h want a5a50001", r_data); end
      n_cmp++; if (r_extra !== 0) begin n_fail++; $display("FAIL hv_no_second_cycle: got %0d want 0", r_extra); end
      n_cmp++; if (r_rel !== 1) begin n_fail++; $display("FAIL hv_release: got %0d want 1", r_rel); end
   endtask

   task automatic test_timeout();
      do_read(32'h0000_3000, 1'b1, 99, 32'hCAFE_F00D, 1'b0, 0);
      n_cmp++; if (r_lat !== 6) begin n_fail++; $display("FAIL to_latency: got %0d want 6", r_lat); end
      n_cmp++; if (r_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_data: got %h want ffffffff", r_data); end
      n_cmp++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", r_err); end
      n_cmp++; if (r_extra !== 0) begin n_fail++; $display("FAIL to_single_pulse: got %0d want 0", r_extra); end
      n_cmp++; if (r_rel !== 2) begin n_fail++; $display("FAIL to_back_to_idle: got %0d want 2", r_rel); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      int busy_seen;
      bus_read_address = 32'h0000_0080; bus_read_code = 1'b0; READY_n = 1'b1;
      bus_read_vaild = 1'b1;
      @(negedge clock);
      @(negedge clock);
      n_cmp++; if (busy !== 1'b1 || BE_n !== 4'h0 || ADS_n !== 1'b1) begin
         n_fail++; $display("FAIL rm_in_t2: got busy=%b be=%h ads=%b want 1/0/1", busy, BE_n, ADS_n);
      end
      #1 reset_n = 1'b0;
      #1;
      n_cmp++; if (ADS_n !== 1'b1) begin n_fail++; $display("FAIL rm_ads: got %b want 1", ADS_n); end
      n_cmp++; if (BE_n !== 4'hF) begin n_fail++; $display("FAIL rm_be: got %h want F", BE_n); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
      n_cmp++; if (bus_read_error !== 1'b0) begin n_fail++; $display("FAIL rm_err: got %b want 0", bus_read_error); end
      n_cmp++; if (bus_read_data !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h want 0", bus_read_data); end
      bus_read_vaild = 1'b0;
      READY_n = 1'b0;
      #1 reset_n = 1'b1;
      pulses = 0; busy_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (bus_read_ready) pulses++;
         if (busy) busy_seen++;
      end
      READY_n = 1'b1;
      n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rm_no_ready: got %0d want 0", pulses); end
      n_cmp++; if (busy_seen !== 0) begin n_fail++; $display("FAIL rm_stays_idle: got %0d want 0", busy_seen); end
      do_read(32'h0000_0084, 1'b0, 0, 32'h0BAD_F00D, 1'b0, 0);
      n_cmp++; if (r_lat !== 3 || r_data !== 32'h0BAD_F00D || r_err !== 1'b0) begin
         n_fail++; $display("FAIL rm_next_read: got lat=%0d data=%h err=%b want 3/0badf00d/0", r_lat, r_data, r_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [4];
      int          waits [4];
      words = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
      waits = '{0, 1, 0, 2};
      READY_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         n_cmp++; if (busy !== 1'b0 || bus_read_ready !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: got busy=%b ready=%b want 0/0", busy, bus_read_ready);
         end
      end
      for (int i = 0; i < 4; i++) begin
         do_read(32'(4 * i), 1'b1, waits[i], words[i], (i == 0), 0);
         n_cmp++; if (r_lat !== 3 + waits[i]) begin
            n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, r_lat, 3 + waits[i]);
         end
         n_cmp++; if (r_data !== words[i] || r_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_data[%0d]: got %h err=%b want %h err=0", i, r_data, r_err, words[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_held_valid();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_read_responder.md
Name: bus_read_responder

Overview:
Responder end of the internal bus read handshake (bus_read_vaild / bus_read_ready / bus_read_address / bus_read_data) driven by the instruction fetch unit.
- Accepts one read request at a time.
- Converts each request into a single non-pipelined 80386-style external memory read cycle (T1/T2 with ADS_n/READY_n).
- Returns the sampled 32-bit word to the initiator.
- A wait-state watchdog guarantees that every accepted request completes.

Parameters:
TIMEOUT_CYCLES, 16, maximum T2 cycles without READY_n before the cycle is aborted with an error (legal range 1..255).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bus_read_vaild  input  1  request from the initiator; held high until bus_read_ready is seen.
- bus_read_ready  output  1  one-cycle completion pulse; bus_read_data is valid in the same cycle.
- bus_read_address  input  32  byte address of the request; bits [1:0] are ignored (word-aligned fetch).
- bus_read_data  output  32  returned word; byte 0 is in bits [7:0].
- bus_read_code  input  1  1 = code fetch, 0 = data read; drives D_C_n.
- bus_read_error  output  1  high together with bus_read_ready when the cycle timed out.
- busy  output  1  high in every state except IDLE.
- ADS_n  output  1  external address strobe, active low.
- A  output  30  external word address, A = bus_read_address[31:2].
- BE_n  output  4  external byte enables, active low.
- W_R_n  output  1  constant 0 (read).
- D_C_n  output  1  data/code select.
- M_IO_n  output  1  constant 1 (memory space).
- D  input  32  external data bus.
- READY_n  input  1  external ready, active low, sampled only in T2.

Behaviour:
- Reset (asynchronous, reset_n low), taking effect immediately:
  - state = IDLE; ADS_n = 1; A = 0; BE_n = 4'hF; D_C_n = 1.
  - bus_read_ready = 0; bus_read_data = 0; bus_read_error = 0; busy = 0; watchdog counter = 0.
  - Reset in the middle of a cycle aborts it; no ready pulse is produced.
- States: IDLE, T1, T2, RESPOND, RELEASE.
- IDLE:
  - If bus_read_vaild = 1 at the edge: latch A = address[31:2] and D_C_n = ~bus_read_code, then go to T1.
  - Otherwise stay in IDLE.
- T1 (exactly 1 cycle): ADS_n = 0, BE_n = 0000. Go to T2 and clear the counter.
- T2:
  - ADS_n = 1; BE_n = 0000; A and D_C_n held stable.
  - If READY_n = 0 at the edge: bus_read_data <= D, bus_read_error <= 0, go to RESPOND.
  - Else if the counter has reached TIMEOUT_CYCLES-1: bus_read_data <= 32'hFFFF_FFFF, bus_read_error <= 1, go to RESPOND.
  - Otherwise increment the counter.
- RESPOND (exactly 1 cycle):
  - bus_read_ready = 1; BE_n = 1111.
  - bus_read_data and bus_read_error hold their values and stay stable until the next RESPOND.
  - Go to RELEASE.
- RELEASE:
  - bus_read_ready = 0.
  - Stay until bus_read_vaild = 0, then go to IDLE. This prevents a stale valid from being taken as a second request.
- Latency: valid sampled at edge N → ADS_n low during cycle N+1 → READY_n first sampled at edge N+2. With zero wait states, bus_read_ready is high during cycle N+3. Each wait state adds 1 cycle.
- Back-to-back requests: an initiator that drops valid on the ready cycle and re-raises it 1 cycle later gets a new T1 no earlier than 2 cycles after RESPOND.
- Request attribute changes (bus_read_address, bus_read_code) after acceptance are ignored until the next IDLE acceptance.
- READY_n asserted outside T2 is ignored. D is sampled only on the completing edge.
- Timeout boundary: READY_n low on the same edge the counter reaches its limit counts as success (ready wins).

Test Plan:
1. Zero wait states:
   - Stimulus: address 32'h0000_1003, code = 1, D = 32'hDEAD_BEEF, READY_n low in the first T2.
   - Required: A = 30'h0000_0400, D_C_n = 0, ADS_n low for exactly 1 cycle, bus_read_ready pulse 3 cycles after valid is sampled, data = DEADBEEF, error = 0.
2. Three wait states:
   - Stimulus: READY_n low on the 4th T2 edge.
   - Required: ready pulse at N+6; A/BE_n stable through all of T2; D values present before the completing edge are not captured.
3. Timeout with TIMEOUT_CYCLES = 4:
   - Stimulus: READY_n held high.
   - Required: after 4 T2 cycles, one ready pulse with data = FFFFFFFF and error = 1; the state then returns to IDLE once valid drops.
4. Held valid:
   - Stimulus: initiator keeps valid high for 5 cycles after the ready pulse.
   - Required: no second ADS_n until valid has been low for at least 1 cycle.
5. Reset mid-T2:
   - Stimulus: reset_n pulsed low between edges.
   - Required: ADS_n = 1, BE_n = F, busy = 0 immediately (asynchronous); no ready pulse; the next request completes normally.
6. Stray READY_n and back-to-back with the fetch-style initiator:
   - Stimulus: READY_n low while in IDLE/T1; then 4 sequential reads at addresses 0, 4, 8, C.
   - Required: stray READY_n is ignored (no early completion); the 4 reads return the 4 programmed words in order, each with error = 0.
